// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer: FSM states and
// pipeline geometry used by the controller and its hazard detector.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_e;

    localparam int REG_IDX_W_DEF = 2;
    localparam int NUM_STAGES    = 5;

endpackage

// File: rtl/pipe_ctrl_raw_hazard_detect.sv
// Combinational RAW hazard detector: flags an ID source register that is still
// pending a write in EX, MA or WB (no forwarding, no regfile write-through).
module raw_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic                 v_id,
    input  logic                 v_ex,
    input  logic                 v_ma,
    input  logic                 v_wb,
    input  logic                 jump,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic                 id_rs1_used,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] ex_dst_reg,
    input  logic                 ex_reg_we,
    input  logic [REG_IDX_W-1:0] ma_dst_reg,
    input  logic                 ma_reg_we,
    input  logic [REG_IDX_W-1:0] wb_dst_reg,
    input  logic                 wb_reg_we,
    output logic                 haz
);

    logic hit_rs1;
    logic hit_rs2;

    always_comb begin
        hit_rs1 = (v_ex & ex_reg_we & (ex_dst_reg == id_rs1))
                | (v_ma & ma_reg_we & (ma_dst_reg == id_rs1))
                | (v_wb & wb_reg_we & (wb_dst_reg == id_rs1));
        hit_rs2 = (v_ex & ex_reg_we & (ex_dst_reg == id_rs2))
                | (v_ma & ma_reg_we & (ma_dst_reg == id_rs2))
                | (v_wb & wb_reg_we & (wb_dst_reg == id_rs2));
        // A resolving jump squashes the ID instruction, so it cannot stall.
        haz = ((id_rs1_used & hit_rs1) | (id_rs2_used & hit_rs2)) & v_id & ~jump;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/MA/WB core: RAW stalls, jump squash,
// debug halt drain/park, per-stage valid tokens and saturating event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic                 id_rs1_used,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] ex_dst_reg,
    input  logic                 ex_reg_we,
    input  logic [REG_IDX_W-1:0] ma_dst_reg,
    input  logic                 ma_reg_we,
    input  logic [REG_IDX_W-1:0] wb_dst_reg,
    input  logic                 wb_reg_we,
    input  logic                 jump_flag_ma,
    input  logic                 halt_req,
    output logic                 pc_hold,
    output logic                 ifid_hold,
    output logic                 flush_if_id,
    output logic                 idex_bubble,
    output logic                 flush_id_ex,
    output logic                 flush_ex_ma,
    output logic                 halt_ack,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int TOKENS = NUM_STAGES - 1;

    pipe_state_e          state_q, state_d;
    logic                 v_id_q, v_id_d;
    logic                 v_ex_q, v_ex_d;
    logic                 v_ma_q, v_ma_d;
    logic                 v_wb_q, v_wb_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [TOKENS-1:0]    tokens;
    logic                 jump;
    logic                 haz;
    logic                 in_run;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign jump   = jump_flag_ma & v_ma_q;
    assign tokens = {v_wb_q, v_ma_q, v_ex_q, v_id_q};
    assign in_run = (state_q == RUN);

    raw_hazard_detect #(.REG_IDX_W(REG_IDX_W)) u_haz (
        .v_id        (v_id_q),
        .v_ex        (v_ex_q),
        .v_ma        (v_ma_q),
        .v_wb        (v_wb_q),
        .jump        (jump),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .ex_dst_reg  (ex_dst_reg),
        .ex_reg_we   (ex_reg_we),
        .ma_dst_reg  (ma_dst_reg),
        .ma_reg_we   (ma_reg_we),
        .wb_dst_reg  (wb_dst_reg),
        .wb_reg_we   (wb_reg_we),
        .haz         (haz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            v_id_q      <= 1'b0;
            v_ex_q      <= 1'b0;
            v_ma_q      <= 1'b0;
            v_wb_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            v_id_q      <= v_id_d;
            v_ex_q      <= v_ex_d;
            v_ma_q      <= v_ma_d;
            v_wb_q      <= v_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_req) state_d = DRAIN;
            // Dropping the request mid-drain aborts back to normal fetch.
            DRAIN:   if (!halt_req) state_d = RUN;
                     else if (~|tokens) state_d = HALTED;
            HALTED:  if (!halt_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Jump beats hazard hold, which beats the drain bubble, so the PC always
    // takes a resolved jump target even while draining.
    always_comb begin
        pc_hold     = ~jump & (haz | ~in_run);
        ifid_hold   = haz;
        flush_if_id = jump | (~in_run & ~haz);
        idex_bubble = haz;
        flush_id_ex = jump;
        flush_ex_ma = jump;
        halt_ack    = (state_q == HALTED);
    end

    always_comb begin
        v_id_d      = flush_if_id ? 1'b0 : (ifid_hold ? v_id_q : 1'b1);
        v_ex_d      = (jump | haz) ? 1'b0 : v_id_q;
        v_ma_d      = jump ? 1'b0 : v_ex_q;
        v_wb_d      = v_ma_q;
        stall_cnt_d = idex_bubble ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = jump ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
